mem_morph_arbiter: RTL and testbench
====================================

Name: mem_morph_arbiter

Overview:
- Round-robin scheduler that shares one MemMorpher 256-bit line-read port between NUM_REQ requesters, e.g. I-fetch, D-refill and prefetch.
- Sequences each read: grant, drive the morpher `valid`/`addr` for one cycle, wait MM_LATENCY cycles, capture the line and its taint, return the response to the granted requester.
- Sits between the core refill requesters and the MemMorpherBB instance in the sim/taint harness.
- Also counts tainted responses for taint_sum.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- MM_LATENCY, 1: cycles from the morpher issue cycle to valid data_out (>=1). With 1, data is captured at the posedge ending the issue cycle, because the morpher fills on negedge.
- IDW, 3: width of resp_id; must satisfy 2**IDW >= NUM_REQ.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-low: state is reset at a posedge where reset==0.
- req_valid  in  NUM_REQ  per-requester read request.
- req_ready  out  NUM_REQ  one-hot grant; a handshake completes when req_valid[i]&req_ready[i].
- req_addr  in  NUM_REQ*64  flat request byte addresses; requester i uses [64i+63:64i].
- req_addr_taint  in  NUM_REQ*64  flat address taint.
- mm_valid  out  1  morpher request strobe.
- mm_addr  out  64  line address to morpher; bits [4:0] always 0.
- mm_addr_taint  out  64  taint of mm_addr.
- mm_data_in_taint  out  256  taint seed for the morpher.
- mm_data_out  in  256  line returned by morpher.
- mm_data_out_taint  in  256  taint of returned line.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  IDW  index of the requester that owns the response.
- resp_data  out  256  captured line.
- resp_data_taint  out  256  captured line taint.
- resp_err  out  1  request address was not 32-byte aligned.
- taint_sum  out  32  saturating count of delivered responses with nonzero resp_data_taint.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values: mm_valid=0, req_ready=0, resp_valid=0, resp_* data/id/err=0, taint_sum=0, rr_last=NUM_REQ-1 (requester 0 has highest priority after reset).
- IDLE: req_ready is combinational one-hot of the winner.
  - Winner = first i with req_valid[i]=1, scanning from (rr_last+1) mod NUM_REQ upward with wrap.
  - If no request is valid, req_ready=0 and the FSM stays in IDLE.
  - On the grant edge: latch addr&~0x1F, addr_taint, id=i, err=|addr[4:0]; set rr_last=i; go to ISSUE.
- req_ready is 0 in every state except IDLE. A requester may drop req_valid at any time before it is granted.
- ISSUE (exactly 1 cycle):
  - mm_valid=1, mm_addr=latched address, mm_addr_taint=latched taint.
  - mm_data_in_taint = all ones if latched addr_taint != 0, else all zeros.
  - Next state: if MM_LATENCY==1, capture mm_data_out and mm_data_out_taint on this edge and go to RESP; otherwise load cnt=MM_LATENCY-2 and go to WAIT.
- mm_valid=0 in all other states; mm_addr and taint outputs hold their last values.
- WAIT: if cnt==0, capture data and taint and go to RESP; else decrement cnt.
- RESP:
  - resp_valid=1; resp_id, resp_data, resp_data_taint and resp_err are stable until accepted.
  - On resp_valid&resp_ready: go to IDLE; if resp_data_taint!=0, increment taint_sum, saturating at 0xFFFFFFFF.
  - If resp_ready is low, hold indefinitely; no new grant is made.
- Misaligned address: the aligned line is still read and resp_err=1. No fault state exists.
- One outstanding request at most. Best throughput is one response per MM_LATENCY+2 cycles (3 cycles at default: IDLE, ISSUE, RESP).
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,… and no requester waits more than NUM_REQ-1 grants.
- Reset taken mid-operation (ISSUE, WAIT or RESP): return to IDLE next edge with all outputs at reset values. The in-flight response is discarded and never presented.
- Width rules: cnt holds at least clog2(MM_LATENCY) bits; resp_id zero-extends the index to IDW.

Test Plan:
- Reset then single request: req_valid=0001, req_addr[0]=0x80001040, mm_data_out=pattern P. Expect req_ready=0001 at cycle 0; mm_valid=1 with mm_addr=0x80001040 at cycle 1; resp_valid=1, resp_id=0, resp_data=P, resp_err=0 at cycle 2; IDLE at cycle 3 with resp_ready=1.
- All four requesters valid for 8 requests with resp_ready tied to 1. Expect grant order 0,1,2,3,0,1,2,3 and one response every 3 cycles.
- Misaligned addr 0x80001047 on requester 2. Expect mm_addr=0x80001040, resp_err=1, resp_id=2.
- Backpressure: resp_ready=0 for 10 cycles while requester 1 is valid. Expect resp_* stable, req_ready=0 and mm_valid=0 throughout; grant to 1 only after the accept.
- Taint: req_addr_taint=0x1 on requester 3, morpher echoes mm_data_in_taint. Expect mm_data_in_taint all ones, resp_data_taint all ones, taint_sum 0→1. An untainted request leaves taint_sum at 1.
- MM_LATENCY=3, with reset driven low during WAIT. Expect IDLE on the next edge, resp_valid never asserted, rr_last=NUM_REQ-1 (the next grant goes to requester 0 when all are valid).

Source files
------------

// File: rtl/mem_morph_arbiter.sv
// Round-robin arbiter sharing one MemMorpher line-read port between NUM_REQ
// requesters; sequences grant, issue, latency wait and response hand-back.
module mem_morph_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int MM_LATENCY = 1,
   parameter int IDW        = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*64-1:0]  req_addr,
   input  logic [NUM_REQ*64-1:0]  req_addr_taint,
   output logic                   mm_valid,
   output logic [63:0]            mm_addr,
   output logic [63:0]            mm_addr_taint,
   output logic [255:0]           mm_data_in_taint,
   input  logic [255:0]           mm_data_out,
   input  logic [255:0]           mm_data_out_taint,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [IDW-1:0]         resp_id,
   output logic [255:0]           resp_data,
   output logic [255:0]           resp_data_taint,
   output logic                   resp_err,
   output logic [31:0]            taint_sum
);

   // state  | meaning
   // IDLE   | pick round-robin winner, req_ready valid combinationally
   // ISSUE  | mm_valid high for one cycle with latched line address
   // WAIT   | count down remaining morpher latency
   // RESP   | hold response until resp_ready
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam int CW = (MM_LATENCY > 1) ? $clog2(MM_LATENCY) : 1;

   logic [1:0]         state;
   logic [IDW-1:0]     rr_last;
   logic [IDW-1:0]     lat_id;
   logic [63:0]        lat_addr;
   logic [63:0]        lat_taint;
   logic               lat_err;
   logic [CW-1:0]      cnt;
   logic [255:0]       cap_data;
   logic [255:0]       cap_taint;
   logic [31:0]        tsum;

   logic               grant_vld;
   logic [IDW-1:0]     win;
   logic [NUM_REQ-1:0] rot;
   int                 idx;
   logic [63:0]        win_addr;
   logic [63:0]        win_taint;

   // Scan starts one past the last winner and wraps.
   always_comb begin
      grant_vld = 1'b0;
      win       = '0;
      rot       = '0;
      idx       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(rr_last) + k) % NUM_REQ;
         rot = req_valid >> idx;
         if (!grant_vld && rot[0]) begin
            grant_vld = 1'b1;
            win       = IDW'(idx);
         end
      end
   end

   assign win_addr  = 64'(req_addr >> (64 * int'(win)));
   assign win_taint = 64'(req_addr_taint >> (64 * int'(win)));

   assign req_ready = (state == S_IDLE && grant_vld) ? (NUM_REQ'(1) << win) : '0;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= S_IDLE;
         rr_last   <= IDW'(NUM_REQ - 1);
         lat_id    <= '0;
         lat_addr  <= '0;
         lat_taint <= '0;
         lat_err   <= 1'b0;
         cnt       <= '0;
         cap_data  <= '0;
         cap_taint <= '0;
         tsum      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  lat_addr  <= win_addr & ~64'h1F;
                  lat_taint <= win_taint;
                  lat_id    <= win;
                  lat_err   <= |win_addr[4:0];
                  rr_last   <= win;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // Latency 1: morpher fills on the negedge inside the issue cycle.
               if (MM_LATENCY == 1) begin
                  cap_data  <= mm_data_out;
                  cap_taint <= mm_data_out_taint;
                  state     <= S_RESP;
               end else begin
                  cnt   <= CW'(MM_LATENCY - 2);
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  cap_data  <= mm_data_out;
                  cap_taint <= mm_data_out_taint;
                  state     <= S_RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               if (resp_ready) begin
                  state <= S_IDLE;
                  if (|cap_taint && tsum != 32'hFFFF_FFFF) begin
                     tsum <= tsum + 32'd1;
                  end
               end
            end
         endcase
      end
   end

   assign mm_valid         = (state == S_ISSUE);
   assign mm_addr          = lat_addr;
   assign mm_addr_taint    = lat_taint;
   assign mm_data_in_taint = {256{|lat_taint}};
   assign resp_valid       = (state == S_RESP);
   assign resp_id          = lat_id;
   assign resp_data        = cap_data;
   assign resp_data_taint  = cap_taint;
   assign resp_err         = lat_err;
   assign taint_sum        = tsum;

endmodule

// File: tb/tb_mem_morph_arbiter.sv
// Directed bench for mem_morph_arbiter: latency-1 instance for arbitration,
// backpressure and taint; latency-3 instance for mid-wait reset.
module tb_mem_morph_arbiter;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          rst_b = 1'b0;
   logic [3:0]    req_valid = '0;
   logic [3:0]    req_valid_b = '0;
   logic [255:0]  req_addr = '0;
   logic [255:0]  req_addr_taint = '0;
   logic [255:0]  mm_data_out = '0;
   logic [255:0]  mm_data_out_taint = '0;
   logic          resp_ready = 1'b1;

   logic [3:0]    req_ready, req_ready_b;
   logic          mm_valid, mm_valid_b;
   logic [63:0]   mm_addr, mm_addr_b, mm_addr_taint, mm_addr_taint_b;
   logic [255:0]  mm_data_in_taint, mm_data_in_taint_b;
   logic          resp_valid, resp_valid_b;
   logic [2:0]    resp_id, resp_id_b;
   logic [255:0]  resp_data, resp_data_b, resp_data_taint, resp_data_taint_b;
   logic          resp_err, resp_err_b;
   logic [31:0]   taint_sum, taint_sum_b;

   int n_chk = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   mem_morph_arbiter #(.NUM_REQ(4), .MM_LATENCY(1), .IDW(3)) dut_a (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_addr_taint(req_addr_taint),
      .mm_valid(mm_valid), .mm_addr(mm_addr), .mm_addr_taint(mm_addr_taint),
      .mm_data_in_taint(mm_data_in_taint),
      .mm_data_out(mm_data_out), .mm_data_out_taint(mm_data_out_taint),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .resp_data_taint(resp_data_taint),
      .resp_err(resp_err), .taint_sum(taint_sum)
   );

   mem_morph_arbiter #(.NUM_REQ(4), .MM_LATENCY(3), .IDW(3)) dut_b (
      .clock(clock), .reset(rst_b),
      .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_addr(req_addr), .req_addr_taint(req_addr_taint),
      .mm_valid(mm_valid_b), .mm_addr(mm_addr_b), .mm_addr_taint(mm_addr_taint_b),
      .mm_data_in_taint(mm_data_in_taint_b),
      .mm_data_out(mm_data_out), .mm_data_out_taint(mm_data_out_taint),
      .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_id(resp_id_b),
      .resp_data(resp_data_b), .resp_data_taint(resp_data_taint_b),
      .resp_err(resp_err_b), .taint_sum(taint_sum_b)
   );

   // Morpher model: fills on negedge, line = address replicated, taint echoed.
   always @(negedge clock) begin
      if (mm_valid) begin
         mm_data_out       <= {4{mm_addr}};
         mm_data_out_taint <= mm_data_in_taint;
      end
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [63:0] a);
      req_addr[64*i +: 64] = a;
   endtask

   function automatic logic [255:0] line(input logic [63:0] a);
      return {4{a}};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a2;
      repeat (2) step();
      reset = 1'b1;
      chk("rst_req_ready", req_ready, 4'b0000);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_mm_valid", mm_valid, 1'b0);
      chk("rst_taint_sum", taint_sum, 32'd0);
      chk("rst_resp_data", resp_data, '0);
      chk("rst_resp_id", resp_id, 3'd0);

      // single request
      set_addr(0, 64'h8000_1040);
      req_valid = 4'b0001;
      #1 chk("t1_grant", req_ready, 4'b0001);
      step();
      req_valid = 4'b0000;
      chk("t1_mm_valid", mm_valid, 1'b1);
      chk("t1_mm_addr", mm_addr, 64'h8000_1040);
      chk("t1_ready_issue", req_ready, 4'b0000);
      step();
      chk("t1_resp_valid", resp_valid, 1'b1);
      chk("t1_resp_id", resp_id, 3'd0);
      chk("t1_resp_data", resp_data, line(64'h8000_1040));
      chk("t1_resp_err", resp_err, 1'b0);
      step();
      chk("t1_idle_resp", resp_valid, 1'b0);
      chk("t1_idle_mm", mm_valid, 1'b0);

      // round robin, all valid
      reset = 1'b0;
      step();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) set_addr(i, 64'h2000_0000 + 64'(i) * 64'h100);
      req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         #1 chk("rr_grant", req_ready, 4'b0001 << (k % 4));
         step();
         step();
         chk("rr_resp_valid", resp_valid, 1'b1);
         chk("rr_resp_id", resp_id, 3'(k % 4));
         chk("rr_resp_data", resp_data, line(64'h2000_0000 + 64'(k % 4) * 64'h100));
         step();
      end
      req_valid = 4'b0000;

      // misaligned on requester 2
      set_addr(2, 64'h8000_1047);
      req_valid = 4'b0100;
      #1 chk("mis_grant", req_ready, 4'b0100);
      step();
      req_valid = 4'b0000;
      chk("mis_mm_addr", mm_addr, 64'h8000_1040);
      step();
      chk("mis_resp_err", resp_err, 1'b1);
      chk("mis_resp_id", resp_id, 3'd2);
      chk("mis_resp_data", resp_data, line(64'h8000_1040));
      step();

      // backpressure: requester 0 in RESP, requester 1 waiting
      resp_ready = 1'b0;
      set_addr(0, 64'h3000_0000);
      set_addr(1, 64'h3000_0020);
      req_valid = 4'b0011;
      #1 chk("bp_grant0", req_ready, 4'b0001);
      step();
      req_valid = 4'b0010;
      step();
      for (int i = 0; i < 10; i++) begin
         chk("bp_resp_valid", resp_valid, 1'b1);
         chk("bp_resp_id", resp_id, 3'd0);
         chk("bp_resp_data", resp_data, line(64'h3000_0000));
         chk("bp_req_ready", req_ready, 4'b0000);
         chk("bp_mm_valid", mm_valid, 1'b0);
         step();
      end
      resp_ready = 1'b1;
      step();
      chk("bp_grant1", req_ready, 4'b0010);
      step();
      req_valid = 4'b0000;
      step();
      chk("bp_resp1_id", resp_id, 3'd1);
      chk("bp_resp1_data", resp_data, line(64'h3000_0020));
      step();

      // taint
      set_addr(3, 64'h4000_0000);
      req_addr_taint[3*64 +: 64] = 64'h1;
      req_valid = 4'b1000;
      #1 chk("tn_grant", req_ready, 4'b1000);
      step();
      req_valid = 4'b0000;
      chk("tn_seed", mm_data_in_taint, {256{1'b1}});
      chk("tn_addr_taint", mm_addr_taint, 64'h1);
      step();
      chk("tn_resp_taint", resp_data_taint, {256{1'b1}});
      chk("tn_sum_before", taint_sum, 32'd0);
      step();
      chk("tn_sum_after", taint_sum, 32'd1);
      req_addr_taint = '0;
      a2 = 64'h4000_0040;
      set_addr(0, a2);
      req_valid = 4'b0001;
      step();
      req_valid = 4'b0000;
      chk("tn_clean_seed", mm_data_in_taint, '0);
      step();
      chk("tn_clean_taint", resp_data_taint, '0);
      step();
      chk("tn_sum_clean", taint_sum, 32'd1);

      // latency 3 instance, reset during WAIT
      req_valid_b = 4'b0100;
      rst_b = 1'b1;
      #1 chk("l3_grant2", req_ready_b, 4'b0100);
      step();
      req_valid_b = 4'b0000;
      chk("l3_issue", mm_valid_b, 1'b1);
      step();
      chk("l3_wait_mm", mm_valid_b, 1'b0);
      chk("l3_wait_resp", resp_valid_b, 1'b0);
      rst_b = 1'b0;
      step();
      chk("l3_rst_resp", resp_valid_b, 1'b0);
      chk("l3_rst_mm", mm_valid_b, 1'b0);
      chk("l3_rst_addr", mm_addr_b, 64'h0);
      chk("l3_rst_id", resp_id_b, 3'd0);
      rst_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("l3_no_resp", resp_valid_b, 1'b0);
         step();
      end
      req_valid_b = 4'hF;
      #1 chk("l3_rr_reset", req_ready_b, 4'b0001);
      step();
      req_valid_b = 4'b0000;
      step();
      chk("l3_wait1", resp_valid_b, 1'b0);
      step();
      chk("l3_wait0", resp_valid_b, 1'b0);
      step();
      chk("l3_resp", resp_valid_b, 1'b1);
      chk("l3_resp_id", resp_id_b, 3'd0);
      step();
      chk("l3_done", resp_valid_b, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
